// File: rtl/scmp_bus_pkg.sv
// Shared types and constants for the SC/MP external bus responder.
// Status byte layout as presented on d_cpu during the address strobe cycle.
package scmp_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StMem,
    StHoldx,
    StDone
  } bus_state_e;

  // Status bit positions; ST_PAGE is the LSB of the 4-bit A15:12 field
  localparam int unsigned ST_PAGE   = 0;
  localparam int unsigned ST_READ   = 4;
  localparam int unsigned ST_IFETCH = 5;
  localparam int unsigned ST_DELAY  = 6;
  localparam int unsigned ST_HALT   = 7;

  localparam logic [7:0] FLOAT_DATA_DEFAULT = 8'hFF;
  localparam int unsigned WDOG_W = 8;

endpackage

// File: rtl/scmp_bus_wdog.sv
// Per-access watchdog: loaded when a backend request starts, counts while waiting,
// and flags expiry on the TIMEOUT-th request cycle. Saturates instead of wrapping.
module scmp_bus_wdog
  import scmp_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expired
);

  // The load cycle is itself the first request cycle, so expiry compares against TIMEOUT-1
  localparam logic [WDOG_W-1:0] Limit = WDOG_W'(TIMEOUT - 1);
  localparam logic [WDOG_W-1:0] CntMax = '1;

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = WDOG_W'(1);
    end else if (count && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = count && (cnt_q >= Limit);

endmodule

// File: rtl/scmp_bus_responder.sv
// Bus-slave end of the SC/MP external bus: decodes strobes, runs a req/ack backend
// access, stretches the core with hold and returns read data on d_rd.
module scmp_bus_responder
  import scmp_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned MIN_WAIT   = 0,
  parameter logic [7:0]  FLOAT_DATA = FLOAT_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ads,
  input  logic [11:0] addr,
  input  logic [7:0]  d_cpu,
  input  logic        rds,
  input  logic        wds,
  output logic [7:0]  d_rd,
  output logic        hold,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        ifetch,
  output logic        halt,
  output logic        timeout_err
);

  localparam logic [3:0] WaitLast = 4'((MIN_WAIT > 0) ? (MIN_WAIT - 1) : 0);
  localparam bus_state_e AfterMem = (MIN_WAIT > 0) ? StHoldx : StDone;

  bus_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        ifetch_q, ifetch_d;
  logic        halt_q, halt_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [3:0]  wait_q, wait_d;

  logic strobe;
  logic wdog_load, wdog_count, wdog_expired;

  scmp_bus_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wdog_load),
    .count   (wdog_count),
    .expired (wdog_expired)
  );

  // Only the strobe matching the latched direction counts; the other one is ignored
  assign strobe = rd_q ? rds : wds;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    ifetch_d   = ifetch_q;
    halt_d     = halt_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wait_d     = wait_q;
    hold       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = wdata_q;
    wdog_load  = 1'b0;
    wdog_count = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The delay status bit carries no meaning for this responder
        if (ads) begin
          addr_d   = {d_cpu[ST_PAGE +: 4], addr};
          rd_d     = d_cpu[ST_READ];
          ifetch_d = d_cpu[ST_IFETCH];
          halt_d   = d_cpu[ST_HALT];
          state_d  = StAddr;
        end
      end
      StAddr: begin
        // Request goes out in the strobe cycle itself to save a cycle of latency
        if (strobe) begin
          hold      = 1'b1;
          mem_req   = 1'b1;
          mem_we    = ~rd_q;
          mem_wdata = d_cpu;
          wdata_d   = d_cpu;
          wdog_load = 1'b1;
          state_d   = StMem;
        end
      end
      StMem: begin
        hold       = 1'b1;
        mem_req    = 1'b1;
        mem_we     = ~rd_q;
        wdog_count = 1'b1;
        if (mem_ack) begin
          if (rd_q) rdata_d = mem_rdata;
          wait_d  = '0;
          state_d = AfterMem;
        end else if (wdog_expired) begin
          if (rd_q) rdata_d = FLOAT_DATA;
          err_d   = 1'b1;
          wait_d  = '0;
          state_d = AfterMem;
        end
      end
      StHoldx: begin
        hold = 1'b1;
        if (wait_q == WaitLast) begin
          state_d = StDone;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StDone: begin
        if (!strobe) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      ifetch_q <= 1'b0;
      halt_q   <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      ifetch_q <= ifetch_d;
      halt_q   <= halt_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
    end
  end

  assign d_rd        = rdata_q;
  assign mem_addr    = addr_q;
  assign ifetch      = ifetch_q;
  assign halt        = halt_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_scmp_bus_responder.sv
// Scoreboard bench: unit 0 (TIMEOUT=4, MIN_WAIT=0) and unit 1 (TIMEOUT=16, MIN_WAIT=3)
// driven by a shared access task against a programmable-latency backend model.
module tb_scmp_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ads[2], rds[2], wds[2], mem_ack[2];
  logic [11:0] addr[2];
  logic [7:0]  d_cpu[2], mem_rdata[2];
  logic [7:0]  d_rd[2], mem_wdata[2];
  logic        hold[2], mem_req[2], mem_we[2], ifetch[2], halt[2], timeout_err[2];
  logic [15:0] mem_addr[2];

  int          bk_dly[2];
  logic [7:0]  bk_data[2];

  typedef struct {
    logic [15:0] maddr;
    logic        we;
    logic        chk_wd;
    logic [7:0]  wd;
    logic [7:0]  rd;
    logic        err;
    int          hold_n;
    int          req_n;
    logic        ifetch;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  scmp_bus_responder #(
    .TIMEOUT    (4),
    .MIN_WAIT   (0),
    .FLOAT_DATA (8'hFF)
  ) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .ads         (ads[0]),
    .addr        (addr[0]),
    .d_cpu       (d_cpu[0]),
    .rds         (rds[0]),
    .wds         (wds[0]),
    .d_rd        (d_rd[0]),
    .hold        (hold[0]),
    .mem_req     (mem_req[0]),
    .mem_we      (mem_we[0]),
    .mem_addr    (mem_addr[0]),
    .mem_wdata   (mem_wdata[0]),
    .mem_rdata   (mem_rdata[0]),
    .mem_ack     (mem_ack[0]),
    .ifetch      (ifetch[0]),
    .halt        (halt[0]),
    .timeout_err (timeout_err[0])
  );

  scmp_bus_responder #(
    .TIMEOUT    (16),
    .MIN_WAIT   (3),
    .FLOAT_DATA (8'hFF)
  ) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .ads         (ads[1]),
    .addr        (addr[1]),
    .d_cpu       (d_cpu[1]),
    .rds         (rds[1]),
    .wds         (wds[1]),
    .d_rd        (d_rd[1]),
    .hold        (hold[1]),
    .mem_req     (mem_req[1]),
    .mem_we      (mem_we[1]),
    .mem_addr    (mem_addr[1]),
    .mem_wdata   (mem_wdata[1]),
    .mem_rdata   (mem_rdata[1]),
    .mem_ack     (mem_ack[1]),
    .ifetch      (ifetch[1]),
    .halt        (halt[1]),
    .timeout_err (timeout_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Acks after bk_dly request cycles (0 = never); holds mem_ack for one cycle
  task automatic backend(input int u);
    int   cnt = 0;
    logic nxt;
    forever begin
      @(negedge clk);
      if (!mem_req[u]) cnt = 0;
      else if (!mem_ack[u]) cnt++;
      nxt = mem_req[u] && !mem_ack[u] && (bk_dly[u] != 0) && (cnt == bk_dly[u]);
      @(posedge clk);
      #1;
      mem_ack[u]   = nxt;
      mem_rdata[u] = nxt ? bk_data[u] : 8'h00;
    end
  endtask

  task automatic access(input int u, input logic [11:0] a, input logic [7:0] st,
                        input logic [7:0] wd, input logic [7:0] rdat, input int dly,
                        input logic [7:0] exp_rd, input logic exp_err, input int min_wait,
                        input int tmo);
    exp_t        e;
    int          h = 0;
    int          r = 0;
    int          cyc = 0;
    logic        done = 1'b0;
    logic [15:0] ma = '0;
    logic        mw = 1'b0;
    logic [7:0]  mwd = '0;

    e.maddr  = {st[3:0], a};
    e.we     = !st[4];
    e.chk_wd = !st[4];
    e.wd     = wd;
    e.rd     = exp_rd;
    e.err    = exp_err;
    e.req_n  = ((dly != 0) && (dly + 1 <= tmo)) ? dly + 1 : tmo;
    e.hold_n = e.req_n + min_wait;
    e.ifetch = st[5];
    e.halt   = st[7];
    exp_q.push_back(e);

    bk_dly[u]  = dly;
    bk_data[u] = rdat;
    @(posedge clk); #1;
    ads[u] = 1'b1; addr[u] = a; d_cpu[u] = st;
    @(posedge clk); #1;
    ads[u] = 1'b0; addr[u] = 12'($urandom); d_cpu[u] = wd;
    if (st[4]) rds[u] = 1'b1;
    else wds[u] = 1'b1;

    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (hold[u]) h++;
      if (mem_req[u]) begin
        r++;
        ma  = mem_addr[u];
        mw  = mem_we[u];
        mwd = mem_wdata[u];
      end
      if (!hold[u] && h > 0) done = 1'b1;
      // Write data is already captured; later bus values must not leak through
      if (r == 2) d_cpu[u] = ~wd;
    end
    check($sformatf("u%0d_hold_drop", u), 32'(done), 32'd1);

    e = exp_q.pop_front();
    check($sformatf("u%0d_mem_addr", u), 32'(ma), 32'(e.maddr));
    check($sformatf("u%0d_mem_we", u), 32'(mw), 32'(e.we));
    if (e.chk_wd) check($sformatf("u%0d_mem_wdata", u), 32'(mwd), 32'(e.wd));
    check($sformatf("u%0d_d_rd", u), 32'(d_rd[u]), 32'(e.rd));
    check($sformatf("u%0d_timeout_err", u), 32'(timeout_err[u]), 32'(e.err));
    check($sformatf("u%0d_hold_cycles", u), 32'(h), 32'(e.hold_n));
    check($sformatf("u%0d_req_cycles", u), 32'(r), 32'(e.req_n));
    check($sformatf("u%0d_ifetch", u), 32'(ifetch[u]), 32'(e.ifetch));
    check($sformatf("u%0d_halt", u), 32'(halt[u]), 32'(e.halt));

    @(posedge clk); #1;
    rds[u] = 1'b0; wds[u] = 1'b0; d_cpu[u] = 8'h00;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      ads[i] = 1'b0; rds[i] = 1'b0; wds[i] = 1'b0; mem_ack[i] = 1'b0;
      addr[i] = '0; d_cpu[i] = '0; mem_rdata[i] = '0; bk_dly[i] = 0; bk_data[i] = '0;
    end
    rst_n = 1'b0;
    fork
      backend(0);
      backend(1);
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_d_rd", 32'(d_rd[0]), 32'h00);
    check("rst_hold", 32'(hold[0]), 32'd0);
    check("rst_mem_req", 32'(mem_req[0]), 32'd0);
    check("rst_timeout_err", 32'(timeout_err[0]), 32'd0);
    check("rst_mem_addr", 32'(mem_addr[0]), 32'h0);
    check("rst_ifetch", 32'(ifetch[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // unit, addr, status, wdata, rdata, ack delay, exp d_rd, exp err, min_wait, timeout
    access(0, 12'h123, 8'h15, 8'h00, 8'hA5, 1, 8'hA5, 1'b0, 0, 4);
    access(0, 12'h0FF, 8'h02, 8'h3C, 8'h00, 2, 8'hA5, 1'b0, 0, 4);
    access(0, 12'h456, 8'h1A, 8'h00, 8'h5A, 3, 8'h5A, 1'b0, 0, 4);
    access(0, 12'h789, 8'h13, 8'h00, 8'h11, 0, 8'hFF, 1'b1, 0, 4);
    access(0, 12'h001, 8'h90, 8'h00, 8'h77, 1, 8'h77, 1'b1, 0, 4);
    access(1, 12'h200, 8'h30, 8'h00, 8'hC3, 1, 8'hC3, 1'b0, 3, 16);
    access(1, 12'h3AB, 8'h0F, 8'h99, 8'h00, 1, 8'hC3, 1'b0, 3, 16);

    // Abandon an access mid-flight with an asynchronous reset
    bk_dly[0] = 0;
    @(posedge clk); #1;
    ads[0] = 1'b1; addr[0] = 12'h555; d_cpu[0] = 8'h11;
    @(posedge clk); #1;
    ads[0] = 1'b0; rds[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_pre_req", 32'(mem_req[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", 32'(mem_req[0]), 32'd0);
    check("mid_rst_hold", 32'(hold[0]), 32'd0);
    check("mid_rst_d_rd", 32'(d_rd[0]), 32'h00);
    check("mid_rst_timeout_err", 32'(timeout_err[0]), 32'd0);
    rds[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    access(0, 12'h0AA, 8'h14, 8'h00, 8'h3E, 1, 8'h3E, 1'b0, 0, 4);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
